// File: rtl/ic_tester_pkg.sv
// Shared constants for the quad-gate IC tester: gate-type codes, sequencer state encoding
// and default timing.
package ic_tester_pkg;

    localparam logic [2:0] GT_AND     = 3'd0;
    localparam logic [2:0] GT_OR      = 3'd1;
    localparam logic [2:0] GT_NAND    = 3'd2;
    localparam logic [2:0] GT_NOR     = 3'd3;
    localparam logic [2:0] GT_XOR     = 3'd4;
    localparam logic [2:0] GT_XNOR    = 3'd5;
    localparam logic [2:0] GT_UNKNOWN = 3'b111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_NEXT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int unsigned DEFAULT_STEP_CYCLES = 50000000;

    function automatic logic type_legal(input logic [2:0] t);
        return t <= GT_XNOR;
    endfunction

endpackage

// File: rtl/round_timer.sv
// Counts one full 4-pattern round of the checker, 0 .. 4*(STEP_CYCLES+1)-1, and pulses
// o_wrap on the last count.
module round_timer #(
    parameter int unsigned STEP_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_wrap
);

    localparam int unsigned ROUND_LEN = 4 * (STEP_CYCLES + 1);
    localparam int unsigned CW        = (ROUND_LEN > 1) ? $clog2(ROUND_LEN) : 1;
    localparam logic [CW-1:0] LAST    = CW'(ROUND_LEN - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_wrap    = i_enable && !i_clear && w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ic_test_sequencer.sv
// Sequencer for the two-input gate checker: runs VERIFY on one gate type or IDENTIFY across
// all types, then latches the per-gate verdict and identified type.
module ic_test_sequencer
    import ic_tester_pkg::*;
#(
    parameter int unsigned STEP_CYCLES   = DEFAULT_STEP_CYCLES,
    parameter int unsigned SETTLE_ROUNDS = 2,
    parameter int unsigned NUM_TYPES     = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_mode,
    input  logic [2:0] i_type_sel,
    input  logic [3:0] i_chk_pass,
    input  logic [3:0] i_chk_fail,
    output logic       o_chk_enable,
    output logic [2:0] o_chk_gate_sel,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_result_valid,
    output logic       o_result_pass,
    output logic [3:0] o_gate_ok,
    output logic [2:0] o_ident_code
);

    localparam int unsigned RW = $clog2(SETTLE_ROUNDS + 2);
    localparam logic [RW-1:0] LAST_ROUND = RW'(SETTLE_ROUNDS);

    logic [2:0]    r_state, w_state_d;
    logic          r_mode, w_mode_d;
    logic [2:0]    r_gate_sel, w_gate_sel_d;
    logic [3:0]    r_gate_ok, w_gate_ok_d;
    logic [2:0]    r_ident, w_ident_d;
    logic          r_valid, w_valid_d;
    logic          r_pass, w_pass_d;
    logic [RW-1:0] r_round;
    logic          w_wrap, w_cnt_clr, w_running;
    logic [3:0]    w_sample_ok;
    logic [2:0]    w_sel_inc;

    assign w_running   = (r_state == ST_RUN);
    assign w_cnt_clr   = !w_running || i_abort;
    assign w_sample_ok = i_chk_pass & ~i_chk_fail;
    assign w_sel_inc   = r_gate_sel + 3'd1;

    round_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_round_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_cnt_clr),
        .i_enable (w_running),
        .o_wrap   (w_wrap)
    );

    always_comb begin
        w_state_d    = r_state;
        w_mode_d     = r_mode;
        w_gate_sel_d = r_gate_sel;
        w_gate_ok_d  = r_gate_ok;
        w_ident_d    = r_ident;
        w_valid_d    = r_valid;
        w_pass_d     = r_pass;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_mode_d     = i_mode;
                    w_valid_d    = 1'b0;
                    w_ident_d    = GT_UNKNOWN;
                    w_gate_sel_d = i_mode ? GT_AND : i_type_sel;
                    if (!i_mode && !type_legal(i_type_sel)) begin
                        w_gate_ok_d = 4'h0;
                        w_state_d   = ST_DONE;
                    end else begin
                        w_state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (i_abort) w_state_d = ST_IDLE;
                else if (w_wrap && r_round == LAST_ROUND) w_state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (i_abort) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_gate_ok_d = w_sample_ok;
                    if (!r_mode) begin
                        w_state_d = ST_DONE;
                    end else if (w_sample_ok == 4'hF) begin
                        w_ident_d = r_gate_sel;
                        w_state_d = ST_DONE;
                    end else begin
                        w_state_d = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (i_abort) begin
                    w_state_d = ST_IDLE;
                end else if (w_sel_inc == 3'(NUM_TYPES)) begin
                    w_gate_ok_d = 4'h0;
                    w_ident_d   = GT_UNKNOWN;
                    w_state_d   = ST_DONE;
                end else begin
                    // Select only moves here, while the checker is disabled.
                    w_gate_sel_d = w_sel_inc;
                    w_state_d    = ST_RUN;
                end
            end
            ST_DONE: w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
        if (w_state_d == ST_DONE) begin
            w_valid_d = 1'b1;
            w_pass_d  = (w_gate_ok_d == 4'hF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= 1'b0;
            r_gate_sel <= 3'd0;
            r_gate_ok  <= 4'h0;
            r_ident    <= GT_UNKNOWN;
            r_valid    <= 1'b0;
            r_pass     <= 1'b0;
            r_round    <= '0;
        end else begin
            r_state    <= w_state_d;
            r_mode     <= w_mode_d;
            r_gate_sel <= w_gate_sel_d;
            r_gate_ok  <= w_gate_ok_d;
            r_ident    <= w_ident_d;
            r_valid    <= w_valid_d;
            r_pass     <= w_pass_d;
            if (w_cnt_clr)   r_round <= '0;
            else if (w_wrap) r_round <= r_round + 1'b1;
        end
    end

    assign o_chk_enable   = (r_state == ST_RUN) || (r_state == ST_SAMPLE);
    assign o_chk_gate_sel = r_gate_sel;
    assign o_busy         = (r_state == ST_RUN) || (r_state == ST_SAMPLE) || (r_state == ST_NEXT);
    assign o_done         = (r_state == ST_DONE);
    assign o_result_valid = r_valid;
    assign o_result_pass  = r_pass;
    assign o_gate_ok      = r_gate_ok;
    assign o_ident_code   = r_ident;

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Directed plus randomized bench for ic_test_sequencer against a socket model and a
// phase-level timing/result model.
module tb_ic_test_sequencer;

    localparam int unsigned STEP   = 3;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned NT     = 6;
    localparam int RUNLEN = (SETTLE + 1) * 4 * (STEP + 1);
    localparam int LIMIT  = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, mode = 1'b0;
    logic [2:0] type_sel = 3'd0;
    logic [3:0] chk_pass, chk_fail;
    logic chk_enable, busy, done, result_valid, result_pass;
    logic [2:0] chk_gate_sel, ident_code;
    logic [3:0] gate_ok;

    logic [3:0] sock_pass [0:7];
    logic [3:0] sock_fail [0:7];

    int total = 0;
    int bad = 0;
    int sel_viol = 0;
    int done_cnt = 0;
    logic prev_en = 1'b0;
    logic [2:0] prev_sel = 3'd0;
    logic [2:0] visited[$];

    always #5 clk = ~clk;

    assign chk_pass = sock_pass[chk_gate_sel];
    assign chk_fail = sock_fail[chk_gate_sel];

    ic_test_sequencer #(
        .STEP_CYCLES   (STEP),
        .SETTLE_ROUNDS (SETTLE),
        .NUM_TYPES     (NT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .i_abort        (abort),
        .i_mode         (mode),
        .i_type_sel     (type_sel),
        .i_chk_pass     (chk_pass),
        .i_chk_fail     (chk_fail),
        .o_chk_enable   (chk_enable),
        .o_chk_gate_sel (chk_gate_sel),
        .o_busy         (busy),
        .o_done         (done),
        .o_result_valid (result_valid),
        .o_result_pass  (result_pass),
        .o_gate_ok      (gate_ok),
        .o_ident_code   (ident_code)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_en && chk_gate_sel !== prev_sel) sel_viol++;
            if (chk_enable && (visited.size() == 0 || visited[$] != chk_gate_sel))
                visited.push_back(chk_gate_sel);
            if (done) done_cnt++;
        end
        prev_en  = chk_enable;
        prev_sel = chk_gate_sel;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outcome from the socket contents and phase lengths.
    task automatic model(input logic m, input logic [2:0] ts, output int cyc,
                         output logic [3:0] ok, output logic ps, output logic [2:0] id,
                         output int nvis);
        int found;
        if (!m) begin
            if (ts > 3'd5) begin
                cyc = 1; ok = 4'h0; nvis = 0;
            end else begin
                cyc = 1 + RUNLEN + 1; ok = sock_pass[ts] & ~sock_fail[ts]; nvis = 1;
            end
            id = 3'b111;
        end else begin
            found = -1;
            for (int t = 0; t < int'(NT); t++)
                if (found < 0 && (sock_pass[t] & ~sock_fail[t]) == 4'hF) found = t;
            if (found >= 0) begin
                cyc = 1 + (found + 1) * (RUNLEN + 1) + found;
                ok = 4'hF; id = 3'(found); nvis = found + 1;
            end else begin
                cyc = 1 + int'(NT) * (RUNLEN + 2);
                ok = 4'h0; id = 3'b111; nvis = int'(NT);
            end
        end
        ps = (ok == 4'hF);
    endtask

    task automatic do_start(input logic m, input logic [2:0] ts);
        @(negedge clk);
        mode = m; type_sel = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic m, input logic [2:0] ts,
                                 input int disturb_at);
        int cyc, nvis, n, dc0, vbad;
        logic [3:0] ok;
        logic ps;
        logic [2:0] id;
        model(m, ts, cyc, ok, ps, id, nvis);
        visited.delete();
        dc0 = done_cnt;
        do_start(m, ts);
        n = 1;
        while (!done && n < LIMIT) begin
            if (n == disturb_at) begin
                start = 1'b1; mode = ~m; type_sel = ts ^ 3'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_cycles"}, n, cyc);
        chk({tag, "_gate_ok"}, gate_ok, ok);
        chk({tag, "_pass"}, result_pass, ps);
        chk({tag, "_ident"}, ident_code, id);
        chk({tag, "_valid"}, result_valid, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        vbad = (visited.size() != nvis) ? 1 : 0;
        for (int i = 0; i < visited.size() && i < nvis; i++)
            if (visited[i] != (m ? 3'(i) : ts)) vbad++;
        chk({tag, "_visits"}, vbad, 0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {done, 8'(done_cnt - dc0)}, {1'b0, 8'd1});
        chk({tag, "_valid_hold"}, {result_valid, result_pass, gate_ok, ident_code},
            {1'b1, ps, ok, id});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_en"}, chk_enable, 0);
        chk({tag, "_sel"}, chk_gate_sel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_pass"}, result_pass, 0);
        chk({tag, "_gate_ok"}, gate_ok, 0);
        chk({tag, "_ident"}, ident_code, 3'b111);
    endtask

    task automatic set_blank();
        for (int t = 0; t < 8; t++) begin
            sock_pass[t] = 4'h0; sock_fail[t] = 4'hF;
        end
    endtask

    initial begin
        int n, dc0;
        set_blank();
        #12;
        check_reset_vals("reset");
        @(negedge clk); rst_n = 1'b1;

        // VERIFY NAND, all gates good; a stray start mid-run must be ignored.
        sock_pass[2] = 4'hF; sock_fail[2] = 4'h0;
        run_and_check("verify_nand", 1'b0, 3'd2, 12);
        chk("verify_nand_no_sel_change", sel_viol, 0);

        // VERIFY with one bad gate.
        sock_pass[1] = 4'hB; sock_fail[1] = 4'h4;
        run_and_check("verify_bad", 1'b0, 3'd1, 0);
        sock_pass[3] = 4'hF; sock_fail[3] = 4'h2;
        run_and_check("verify_both_flags", 1'b0, 3'd3, 0);

        // IDENTIFY XOR.
        for (int t = 0; t < 8; t++) begin
            sock_pass[t] = 4'($urandom) & 4'h7; sock_fail[t] = 4'($urandom);
        end
        sock_pass[4] = 4'hF; sock_fail[4] = 4'h0;
        sock_pass[5] = 4'hF; sock_fail[5] = 4'h0;
        run_and_check("ident_xor", 1'b1, 3'd6, 0);

        set_blank();
        run_and_check("ident_blank", 1'b1, 3'd0, 0);
        chk("ident_no_sel_change", sel_viol, 0);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            for (int t = 0; t < 8; t++) begin
                if ($urandom_range(0, 4) == 0) begin
                    sock_pass[t] = 4'hF; sock_fail[t] = 4'h0;
                end else begin
                    sock_pass[t] = 4'($urandom); sock_fail[t] = 4'($urandom);
                end
            end
            run_and_check($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), 0);
        end

        // Abort mid-RUN.
        dc0 = done_cnt;
        do_start(1'b0, 3'd0);
        repeat (19) @(posedge clk);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("abort_en", chk_enable, 0);
        chk("abort_busy", busy, 0);
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - dc0, 0);
        chk("abort_valid", result_valid, 0);
        sock_pass[0] = 4'hF; sock_fail[0] = 4'h0;
        run_and_check("after_abort", 1'b0, 3'd0, 0);

        // start and abort together in IDLE.
        dc0 = done_cnt;
        @(negedge clk); start = 1'b1; abort = 1'b1; mode = 1'b0; type_sel = 3'd1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("start_abort_idle", {busy, chk_enable, result_valid}, 3'b001);
        chk("start_abort_no_done", done_cnt - dc0, 0);

        // Reset in IDENTIFY while select 3 is under test.
        set_blank();
        do_start(1'b1, 3'd0);
        n = 0;
        while (!(chk_enable && chk_gate_sel == 3'd3) && n < LIMIT) begin
            @(posedge clk); #1; n++;
        end
        chk("reach_sel3", chk_gate_sel, 3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk); #1 rst_n = 1'b1;
        run_and_check("illegal_type", 1'b0, 3'd6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
